// File: rtl/cpu_mem_if_if.sv
// Signal bundle between the CPU/front panel side and the memory controller.
// The master drives the CPU strobes, loader stream and debug address; the slave answers.
interface cpu_mem_if_if #(
  parameter int unsigned AW = 8
);
  logic [1:0]    cpustate;
  logic [15:0]   addr;
  logic [7:0]    data_out;
  logic          read;
  logic          write;
  logic [7:0]    data_in;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic          busy;
  logic          err;
  logic [AW-1:0] dbg_addr;
  logic [7:0]    dbg_data;

  modport master (
    output cpustate, addr, data_out, read, write, ld_valid, ld_data, dbg_addr,
    input  data_in, ld_ready, ld_count, busy, err, dbg_data
  );

  modport slave (
    input  cpustate, addr, data_out, read, write, ld_valid, ld_data, dbg_addr,
    output data_in, ld_ready, ld_count, busy, err, dbg_data
  );
endinterface

// File: rtl/cpu_mem_if.sv
// Byte-wide program/data memory with zero-fill after reset, a valid/ready program loader,
// CPU read/write service in RUN mode and a combinational debug read port.
module cpu_mem_if #(
  parameter int unsigned AW     = 8,
  parameter logic [1:0]  ST_LD  = 2'b01,
  parameter logic [1:0]  ST_RUN = 2'b10
) (
  input logic         clk,
  input logic         rst,
  cpu_mem_if_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {StClear, StIdle, StLoad, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [AW:0]   ld_count_q, ld_count_d;
  logic          err_q, err_d;
  logic [7:0]    mem_q [DEPTH];

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          addr_ok;
  logic          ld_ready;
  logic          ld_xfer;
  logic          run_rd;

  assign addr_ok  = (bus.addr >> AW) == 16'd0;
  // The count's top bit is set exactly when all DEPTH bytes have been loaded.
  assign ld_ready = (state_q == StLoad) && !ld_count_q[AW];
  assign ld_xfer  = ld_ready && bus.ld_valid;
  assign run_rd   = (state_q == StRun) && bus.read && !bus.write && addr_ok;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_count_d = ld_count_q;
    err_d      = err_q;
    we         = 1'b0;
    waddr      = clr_ptr_q;
    wdata      = 8'h00;
    unique case (state_q)
      StClear: begin
        we        = 1'b1;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (&clr_ptr_q) state_d = StIdle;
      end
      StIdle: begin
        if (bus.cpustate == ST_LD) begin
          state_d    = StLoad;
          ld_count_d = '0;
        end else if (bus.cpustate == ST_RUN) begin
          state_d = StRun;
        end
      end
      StLoad: begin
        if (ld_xfer) begin
          we         = 1'b1;
          waddr      = ld_count_q[AW-1:0];
          wdata      = bus.ld_data;
          ld_count_d = ld_count_q + (AW+1)'(1);
        end
        if (bus.ld_valid && !ld_ready) err_d = 1'b1;
        if (bus.cpustate != ST_LD) state_d = StIdle;
      end
      StRun: begin
        if (bus.write && addr_ok) begin
          we    = 1'b1;
          waddr = bus.addr[AW-1:0];
          wdata = bus.data_out;
        end
        if ((bus.read && bus.write) || ((bus.read || bus.write) && !addr_ok)) err_d = 1'b1;
        if (bus.cpustate != ST_RUN) state_d = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      ld_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_count_q <= ld_count_d;
      err_q      <= err_d;
    end
  end

  // No reset on the array itself: the CLEAR pass zero-fills it.
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= wdata;
  end

  assign bus.data_in  = run_rd ? mem_q[bus.addr[AW-1:0]] : 8'h00;
  assign bus.busy     = (state_q == StClear);
  assign bus.dbg_data = bus.busy ? 8'h00 : mem_q[bus.dbg_addr];
  assign bus.ld_ready = ld_ready;
  assign bus.ld_count = ld_count_q;
  assign bus.err      = err_q;
endmodule
